// File: rtl/hamming_frame_decoder.sv
// Serial frame decoder: hunts for a sync header, then decodes eight Hamming(7,4)
// codewords per frame into a 32-bit payload, with flywheel lock tracking.
module hamming_frame_decoder #(
    parameter logic [7:0] HEADER     = 8'b01111110,
    parameter int         MISS_LIMIT = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        data_in,
    input  logic        data_valid,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic [7:0]  corr_mask,
    output logic        locked,
    output logic [8:0]  frame_count,
    output logic        sync_loss
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HEADER  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  window_q, window_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [55:0] payload_q, payload_d;
    logic [2:0]  miss_q, miss_d;
    logic [31:0] data_out_q, data_out_d;
    logic [7:0]  corr_mask_q, corr_mask_d;
    logic        data_out_valid_q, data_out_valid_d;
    logic        locked_q, locked_d;
    logic [8:0]  frame_count_q, frame_count_d;
    logic        sync_loss_q, sync_loss_d;

    logic [7:0]  win_next_s;
    logic [55:0] payload_full_s;
    logic [31:0] nibbles_s;
    logic [7:0]  corr_s;
    logic [2:0]  miss_inc_s;

    // Returns {corrected, nibble}; a nonzero syndrome names the position to flip.
    function automatic logic [4:0] decode_cw(input logic [6:0] cw);
        logic [2:0] syn;
        logic [6:0] fixed;
        syn = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (cw[k]) begin
                syn = syn ^ 3'(k + 1);
            end else begin
                syn = syn;
            end
        end
        if (syn != 3'd0) begin
            fixed = cw ^ (7'd1 << (syn - 3'd1));
        end else begin
            fixed = cw;
        end
        return {(syn != 3'd0), fixed[6], fixed[5], fixed[4], fixed[2]};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'd0, v[k]};
        end
        return n;
    endfunction

    // Payload decode: the codeword in bits [7i+6:7i] carries nibble i.
    always_comb begin
        payload_full_s = {payload_q[54:0], data_in};
        nibbles_s      = 32'd0;
        corr_s         = 8'd0;
        for (int i = 0; i < 8; i++) begin
            {corr_s[i], nibbles_s[4*i +: 4]} = decode_cw(payload_full_s[7*i +: 7]);
        end
    end

    // Next-state and output logic; idle cycles leave everything untouched.
    always_comb begin
        state_d          = state_q;
        window_d         = window_q;
        bit_cnt_d        = bit_cnt_q;
        payload_d        = payload_q;
        miss_d           = miss_q;
        data_out_d       = data_out_q;
        corr_mask_d      = corr_mask_q;
        frame_count_d    = frame_count_q;
        data_out_valid_d = 1'b0;
        sync_loss_d      = 1'b0;
        win_next_s       = {window_q[6:0], data_in};
        miss_inc_s       = miss_q + 3'd1;
        if (data_valid) begin
            case (state_q)
                ST_HUNT: begin
                    window_d = win_next_s;
                    if (win_next_s == HEADER) begin
                        state_d   = ST_PAYLOAD;
                        bit_cnt_d = 6'd0;
                    end else begin
                        state_d   = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    payload_d = payload_full_s;
                    if (bit_cnt_q == 6'd55) begin
                        state_d          = ST_HEADER;
                        bit_cnt_d        = 6'd0;
                        data_out_d       = nibbles_s;
                        corr_mask_d      = corr_s;
                        data_out_valid_d = 1'b1;
                        frame_count_d    = frame_count_q + 9'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                ST_HEADER: begin
                    window_d = win_next_s;
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = 6'd0;
                        if (popcount8(win_next_s ^ HEADER) <= 4'd1) begin
                            miss_d  = 3'd0;
                            state_d = ST_PAYLOAD;
                        end else if (miss_inc_s == 3'(MISS_LIMIT)) begin
                            miss_d      = 3'd0;
                            state_d     = ST_HUNT;
                            window_d    = 8'd0;
                            sync_loss_d = 1'b1;
                        end else begin
                            miss_d  = miss_inc_s;
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    window_d  = 8'd0;
                    bit_cnt_d = 6'd0;
                    miss_d    = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d != ST_HUNT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q          <= ST_HUNT;
            window_q         <= 8'd0;
            bit_cnt_q        <= 6'd0;
            payload_q        <= 56'd0;
            miss_q           <= 3'd0;
            data_out_q       <= 32'd0;
            corr_mask_q      <= 8'd0;
            data_out_valid_q <= 1'b0;
            locked_q         <= 1'b0;
            frame_count_q    <= 9'd0;
            sync_loss_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            window_q         <= window_d;
            bit_cnt_q        <= bit_cnt_d;
            payload_q        <= payload_d;
            miss_q           <= miss_d;
            data_out_q       <= data_out_d;
            corr_mask_q      <= corr_mask_d;
            data_out_valid_q <= data_out_valid_d;
            locked_q         <= locked_d;
            frame_count_q    <= frame_count_d;
            sync_loss_q      <= sync_loss_d;
        end
    end

    assign data_out       = data_out_q;
    assign corr_mask      = corr_mask_q;
    assign data_out_valid = data_out_valid_q;
    assign locked         = locked_q;
    assign frame_count    = frame_count_q;
    assign sync_loss      = sync_loss_q;

endmodule
